program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/common.sv | 11 +
 rtl/word_assembler.sv | 22 ++
 rtl/program_loader.sv | 103 ++++++++++
 tb/tb_program_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types for the program loader slice.
package common;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    WRITE,
    DONE
  } loader_state_type;

endpackage

// File: rtl/word_assembler.sv
// Collects little-endian bytes into a 32-bit word, one lane per accepted byte.
module word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        load,
  input  logic [1:0]  index,
  input  logic [7:0]  byte_data,
  output logic [31:0] word
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      word[{index, 3'b000} +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into program memory word by word while holding the CPU in reset.
module program_loader
  import common::*;
#(
  parameter int unsigned MEM_WORDS  = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] load_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-2:0] ONE_WORD  = (ADDR_WIDTH-1)'(1);
  localparam logic [ADDR_WIDTH-2:0] MAX_WORDS = (ADDR_WIDTH-1)'(MEM_WORDS);

  loader_state_type      state;
  loader_state_type      state_next;
  logic [ADDR_WIDTH-2:0] word_idx;
  logic [ADDR_WIDTH-2:0] last_idx;
  logic [1:0]            byte_idx;
  logic                  accept;
  logic                  start_ok;
  logic                  last_byte;

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && (load_words != '0) && (load_words <= MAX_WORDS);
  assign last_byte = accept && (byte_idx == 2'd3);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RECEIVE;
      RECEIVE: if (last_byte) state_next = WRITE;
      WRITE:   state_next = (word_idx == last_idx) ? DONE : RECEIVE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      word_idx         <= '0;
      last_idx         <= '0;
      byte_idx         <= '0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      byte_ready       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      cpu_reset_n      <= 1'b1;
    end else begin
      state            <= state_next;
      byte_ready       <= (state_next == RECEIVE);
      busy             <= (state_next == RECEIVE) || (state_next == WRITE);
      mem_write_enable <= (state_next == WRITE);
      done             <= (state_next == DONE);
      cpu_reset_n      <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (start_ok) begin
            word_idx <= '0;
            byte_idx <= '0;
            last_idx <= load_words - ONE_WORD;
            error    <= 1'b0;
          end else if (start) begin
            error <= 1'b1;
          end
        end
        RECEIVE: begin
          if (accept) byte_idx <= byte_idx + 2'd1;
          if (last_byte) mem_address <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
        end
        WRITE:   word_idx <= word_idx + ONE_WORD;
        default: ;
      endcase
    end
  end

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     ((state == IDLE) && start_ok),
    .load      (accept),
    .index     (byte_idx),
    .byte_data (byte_data),
    .word      (mem_write_data)
  );

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected writes, a monitor checks them.
module tb_program_loader;

  localparam int unsigned MEM_WORDS  = 8;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-2:0] load_words = '0;
  logic                  byte_valid = 1'b0;
  logic [7:0]            byte_data = '0;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write_enable;
  logic [31:0]           mem_write_data;
  logic                  cpu_reset_n;
  logic                  busy;
  logic                  done;
  logic                  error;

  int unsigned errors = 0;
  int unsigned checks = 0;
  wr_t         exp_q[$];
  wr_t         mon_exp;

  logic [7:0]  bytes_a[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0]  bytes_b[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [31:0] full_words[8] = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130,
                                 32'h43424140, 32'h53525150, 32'h63626160, 32'h73727170};

  always #5 clk = ~clk;

  program_loader #(
    .MEM_WORDS  (MEM_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .load_words       (load_words),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .cpu_reset_n      (cpu_reset_n),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h, expected no write",
                 mem_address, mem_write_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr", 32'(mem_address), 32'(mon_exp.addr));
        check("write_data", mem_write_data, mon_exp.data);
      end
    end
  end

  task automatic do_start(input logic [ADDR_WIDTH-2:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    load_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned w = 0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got byte_ready=0 after %0d cycles, expected 1", w);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], 0);
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned c = 0;
    logic seen = 1'b0;
    while (!seen && c < limit) begin
      @(negedge clk);
      c++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("busy_at_done", 32'(busy), 32'd0);
      check("cpu_hold_at_done", 32'(cpu_reset_n), 32'd0);
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
      check("cpu_released", 32'(cpu_reset_n), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_data", mem_write_data, 32'd0);
    reset_n = 1'b1;

    // Two-word program
    exp_q.push_back('{addr: 5'h00, data: 32'h00000013});
    exp_q.push_back('{addr: 5'h04, data: 32'h00100093});
    do_start(4'd2);
    check("load_busy", 32'(busy), 32'd1);
    check("load_cpu_hold", 32'(cpu_reset_n), 32'd0);
    check("load_byte_ready", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(bytes_a[i], 0);
    wait_done(10);

    // Rejected word counts
    do_start(4'd0);
    check("err_zero", 32'(error), 32'd1);
    check("err_zero_idle", 32'(busy), 32'd0);
    check("err_zero_cpu", 32'(cpu_reset_n), 32'd1);
    do_start(4'd9);
    check("err_nine", 32'(error), 32'd1);
    check("err_nine_ready", 32'(byte_ready), 32'd0);

    // Single word with gaps; also clears error
    exp_q.push_back('{addr: 5'h00, data: 32'hDEADBEEF});
    do_start(4'd1);
    check("err_cleared", 32'(error), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(bytes_b[i], 3);
    wait_done(10);

    // Full memory
    for (int i = 0; i < 8; i++) exp_q.push_back('{addr: 5'(i * 4), data: full_words[i]});
    do_start(4'd8);
    for (int i = 0; i < 8; i++) send_word(full_words[i]);
    wait_done(10);
    repeat (10) @(negedge clk);
    check("full_all_written", 32'(exp_q.size()), 32'd0);

    // Reset mid-load abandons the partial second word
    exp_q.push_back('{addr: 5'h00, data: 32'h44332211});
    do_start(4'd2);
    send_word(32'h44332211);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_cpu", 32'(cpu_reset_n), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(byte_ready), 32'd0);
    check("midrst_data", mem_write_data, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_still_idle", 32'(busy), 32'd0);
    check("midrst_first_written", 32'(exp_q.size()), 32'd0);

    // Start pulsed during RECEIVE must be ignored
    exp_q.push_back('{addr: 5'h00, data: 32'hA0B0C0D0});
    exp_q.push_back('{addr: 5'h04, data: 32'h01234567});
    do_start(4'd2);
    send_byte(8'hD0, 0);
    @(posedge clk); #1;
    start = 1'b1;
    load_words = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_ignored_busy", 32'(busy), 32'd1);
    send_byte(8'hC0, 0);
    send_byte(8'hB0, 0);
    send_byte(8'hA0, 0);
    send_word(32'h01234567);
    wait_done(10);
    check("restart_no_error", 32'(error), 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
